// File: rtl/lu_scheduler_if.sv
// lu_scheduler_if: bundle of request, shared-unit and response signals
// between the client blocks, lu_scheduler and the external logical unit.
//   slave  : scheduler side (accepts requests, drives the unit, returns rsp)
//   master : environment side (requesters, logical unit, rsp consumer)
// Requester i occupies req_a/req_b[i*WIDTH +: WIDTH] and req_func[i*4 +: 4].
interface lu_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_func;
  logic                  lu_a;
  logic                  lu_b;
  logic [3:0]            lu_func;
  logic                  lu_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, req_func, lu_out, rsp_ready,
    output req_ready, lu_a, lu_b, lu_func, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, req_func, lu_out, rsp_ready,
    input  req_ready, lu_a, lu_b, lu_func, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/lu_scheduler.sv
// lu_scheduler: round-robin scheduler sharing one bit-serial 2-input
// logical unit (out = func[{a,b}]) among NREQ requesters.
//   clk         : clock, rising edge
//   rst         : synchronous reset, active-high
//   bus (slave) : request channel (valid/ready per requester), shared-unit
//                 drive (lu_a/lu_b/lu_func, lu_out back), response channel
//                 (rsp_valid/rsp_ready, rsp_id, rsp_data)
//   busy_cycles : only with LU_BUSY_CNT_EN defined; saturating count of
//                 cycles spent in RUN
// Flow: IDLE grants one request and latches it, RUN drives the unit one bit
// per cycle LSB first for WIDTH cycles, DONE holds the result until taken.
module lu_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  lu_scheduler_if.slave bus
`ifdef LU_BUSY_CNT_EN
  ,
  output logic [15:0]   busy_cycles
`endif
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [3:0]       r_func;
  logic [IDW-1:0]   r_id, r_last;
  logic [IW-1:0]    r_idx;
  logic             r_rsp_valid;

  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt;

  // Rotating priority: start just after the last grant, first valid wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(r_last) + k) % NREQ;
      if (!w_gnt_vld && bus.req_valid[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = IDW'(j);
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE && w_gnt_vld) ?
                         (NREQ'(1) << w_gnt) : '0;

  assign bus.lu_a    = (r_state == S_RUN) ? r_a[r_idx] : 1'b0;
  assign bus.lu_b    = (r_state == S_RUN) ? r_b[r_idx] : 1'b0;
  assign bus.lu_func = (r_state == S_RUN) ? r_func     : 4'h0;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_id        <= '0;
      r_res       <= '0;
      r_idx       <= '0;
      r_last      <= IDW'(NREQ-1);
      r_a         <= '0;
      r_b         <= '0;
      r_func      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_a     <= bus.req_a[w_gnt*WIDTH +: WIDTH];
            r_b     <= bus.req_b[w_gnt*WIDTH +: WIDTH];
            r_func  <= bus.req_func[w_gnt*4 +: 4];
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res[r_idx] <= bus.lu_out;
          r_idx        <= r_idx + 1'b1;
          if (r_idx == IW'(WIDTH-1)) begin
            r_idx       <= '0;
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LU_BUSY_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      busy_cycles <= '0;
    else if (r_state == S_RUN && busy_cycles != 16'hFFFF)
      busy_cycles <= busy_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lu_scheduler.sv
// tb_lu_scheduler: directed bench for lu_scheduler (NREQ=4, WIDTH=8).
// Models the external logical unit as lu_out = lu_func[{lu_a,lu_b}].
// Inputs are driven and outputs sampled at the falling edge.
module tb_lu_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

`ifdef LU_BUSY_CNT_EN
  logic [15:0] busy_cycles;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lu_scheduler_if #(.NREQ(4), .WIDTH(8), .IDW(2)) bus ();

  assign bus.lu_out = bus.lu_func[{bus.lu_a, bus.lu_b}];

  lu_scheduler #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LU_BUSY_CNT_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f);
    bus.req_a[i*8 +: 8]    = a;
    bus.req_b[i*8 +: 8]    = b;
    bus.req_func[i*4 +: 4] = f;
  endtask

  // Returns the granted index, or -1 if no grant within the budget.
  task automatic wait_gnt(output int g);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 40) begin
      step();
      #1;
      n++;
    end
    g = -1;
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = i;
  endtask

  // Counts falling edges until rsp_valid (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int g, n, c, pc;
    int exp_g [5] = '{0, 1, 2, 3, 0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_func  = '0;
    bus.rsp_ready = 1'b1;
    do_reset();

    // reset state
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  0);
    chk("rst_lu_func",   32'(bus.lu_func),   0);

    // 1: XOR on req0
    set_req(0, 8'hF0, 8'hCC, 4'b0110);
    bus.req_valid = 4'b0001;
    #1;
    chk("xor_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    chk("xor_lu_func", 32'(bus.lu_func), 32'h6);
    chk("xor_lu_ab",   32'({bus.lu_a, bus.lu_b}), 0);
    wait_rsp(n);
    chk("xor_latency", 32'(n), 8);
    chk("xor_data", 32'(bus.rsp_data), 32'h3C);
    chk("xor_id",   32'(bus.rsp_id),   0);
    step();
    chk("xor_valid_drop", 32'(bus.rsp_valid), 0);

    // 2: AND then OR on req1
    set_req(1, 8'hF0, 8'hCC, 4'b1000);
    bus.req_valid = 4'b0010;
    wait_gnt(g);
    chk("and_gnt", 32'(g), 1);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("and_data", 32'(bus.rsp_data), 32'hC0);
    chk("and_id",   32'(bus.rsp_id),   1);
    step();
    set_req(1, 8'hF0, 8'hCC, 4'b1110);
    bus.req_valid = 4'b0010;
    wait_gnt(g);
    chk("or_gnt", 32'(g), 1);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("or_data", 32'(bus.rsp_data), 32'hFC);
    step();

    // 3: round robin, all requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'hFF, 4'b0110);
    bus.req_valid = 4'b1111;
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g);
      c = cyc;
      chk("rr_gnt", 32'(g), 32'(exp_g[i]));
      chk("rr_onehot", 32'($onehot(bus.req_ready)), 1);
      if (i > 0) chk("rr_interval", 32'(c - pc), 10);
      pc = c;
      step();
    end
    bus.req_valid = '0;
    wait_rsp(n);
    chk("rr_last_data", 32'(bus.rsp_data), 32'hFF);
    step();

    // 4: back-pressure on req2, req0 arrives during DONE
    do_reset();
    set_req(2, 8'hAA, 8'h0F, 4'b0110);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    wait_gnt(g);
    chk("bp_gnt", 32'(g), 2);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("bp_latency", 32'(n), 8);
    set_req(0, 8'h5A, 8'h3C, 4'b0000);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_data",  32'(bus.rsp_data),  32'hA5);
      chk("bp_id",    32'(bus.rsp_id),    2);
      chk("bp_ready0", 32'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    #1;
    chk("bp_released", 32'(bus.rsp_valid), 0);
    chk("bp_next_gnt", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("func0_data", 32'(bus.rsp_data), 32'h00);
    chk("func0_id",   32'(bus.rsp_id),   0);
    step();
    set_req(0, 8'h12, 8'h34, 4'b1111);
    bus.req_valid = 4'b0001;
    wait_gnt(g);
    chk("funcF_gnt", 32'(g), 0);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("funcF_data", 32'(bus.rsp_data), 32'hFF);
    step();

    // 5: reset during RUN at idx 3
    do_reset();
    set_req(0, 8'hFF, 8'h00, 4'b0110);
    bus.req_valid = 4'b0001;
    wait_gnt(g);
    chk("mid_gnt", 32'(g), 0);
    step();
    step();
    step();
    step();
    chk("mid_lu_ab",   32'({bus.lu_a, bus.lu_b}), 32'h2);
    chk("mid_lu_func", 32'(bus.lu_func), 32'h6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(1, 8'h01, 8'h01, 4'b0110);
    bus.req_valid = 4'b0011;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_lu_zero", 32'({bus.lu_a, bus.lu_b, bus.lu_func}), 0);
    chk("mid_regrant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0010;
    wait_rsp(n);
    chk("mid_latency", 32'(n), 8);
    chk("mid_data", 32'(bus.rsp_data), 32'hFF);
    chk("mid_id",   32'(bus.rsp_id),   0);
    step();
    wait_gnt(g);
    chk("mid_then1", 32'(g), 1);
    step();
    bus.req_valid = '0;
    wait_rsp(n);
    chk("mid_req1_data", 32'(bus.rsp_data), 32'h00);
    step();

    // 6: three back-to-back ops from req3
    do_reset();
    set_req(3, 8'h0F, 8'hFF, 4'b1000);
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(g);
      chk("b2b_gnt", 32'(g), 3);
      step();
      if (i == 2) bus.req_valid = '0;
      wait_rsp(n);
      chk("b2b_data", 32'(bus.rsp_data), 32'h0F);
      step();
    end
`ifdef LU_BUSY_CNT_EN
    chk("busy_cycles", 32'(busy_cycles), 24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lu_scheduler.md
Name: lu_scheduler

Overview:
Round-robin scheduler that shares one bit-serial 2-input logical unit among NREQ requesters. The logical unit computes out = func[{a,b}]. Each requester submits WIDTH-bit operands a and b plus a 4-bit func code. The scheduler grants one request, drives the shared unit one bit per cycle (LSB first), and assembles the result. It returns the result on a valid/ready response channel tagged with the requester id. The block sits between client blocks and the single logicalunit instance; the unit itself is external and combinational.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits (2..32)
IDW, 2, id width, must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_a  input  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand b, same packing
req_func  input  NREQ*4  func code, requester i at [i*4 +: 4]
lu_a  output  1  bit to shared unit input a
lu_b  output  1  bit to shared unit input b
lu_func  output  4  func to shared unit
lu_out  input  1  shared unit result (combinational from lu_a/lu_b/lu_func)
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester that owns the result
rsp_data  output  WIDTH  assembled result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; rsp_valid=0; rsp_id=0; rsp_data=0; bit index=0; last_grant=NREQ-1, so requester 0 wins first.
- State IDLE:
  - lu_a=0, lu_b=0, lu_func=0.
  - If any req_valid is high, grant g = first valid index scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge, latch a, b, func and id=g; set idx=0; last_grant=g; go to RUN.
  - req_ready is 0 in every state other than IDLE.
- State RUN:
  - lu_a=a_reg[idx], lu_b=b_reg[idx], lu_func=func_reg.
  - Each edge: res[idx]<=lu_out and idx<=idx+1.
  - When idx==WIDTH-1 at the edge, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- State DONE:
  - rsp_valid=1; rsp_data=res and rsp_id=id, both stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - lu_* outputs are 0 in DONE.
- Latency: request accepted in cycle T; rsp_valid first high in cycle T+WIDTH+1.
  - Best-case issue interval is WIDTH+2 cycles (one IDLE grant cycle, then a new grant).
- Requester contract: once req_valid is high, operands stay stable until req_ready is seen. The scheduler never drops a pending request.
- Simultaneous events:
  - A request arriving in DONE waits; it is arbitrated in the next IDLE cycle.
  - Requests from all NREQ requesters are served in strict rotation; no starvation.
  - Worst-case wait is NREQ*(WIDTH+2) cycles plus response back-pressure time.
- Reset mid-operation: the in-flight op is discarded and no response is issued. rsp_valid is low the cycle after rst.
- func is used verbatim; any 4-bit code is legal, including 0000 (result 0) and 1111 (result all ones).

Optional Feature:
- Macro LU_BUSY_CNT_EN.
- Defined: adds output port busy_cycles [15:0]. It counts cycles spent in RUN, saturates at 16'hFFFF and resets to 0 on rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. Single XOR (WIDTH=8): req0 a=8'hF0 b=8'hCC func=4'b0110 -> req_ready[0] in the same cycle; rsp_valid 9 cycles later with rsp_data=8'h3C, rsp_id=0.
2. AND and OR: req1 a=8'hF0 b=8'hCC func=4'b1000 -> rsp_data=8'hC0, id=1. Then func=4'b1110 -> rsp_data=8'hFC.
3. Round-robin: all four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0, each grant 10 cycles apart.
4. Back-pressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable throughout; req_ready stays 0; next grant only after the handshake.
5. Reset mid-RUN: assert rst at idx=3 -> no response; rsp_valid=0 and lu_*=0 after reset; req0 is re-granted first afterwards.
6. With LU_BUSY_CNT_EN defined: three back-to-back ops at WIDTH=8 -> busy_cycles=24.
